hazard_controller: RTL

Pipeline sequencing controller for the two-slot (ALU + MEM) VLIW core. It sits beside the ID stage and drives the PC, IF/ID (p1) and ID/EX (p2) pipeline-register enables. It handles four cases: load-use stalls between the MEM slot in EX and either slot in ID; wrong-path squashes on jumps (resolved in ID) and taken branches (resolved in EX); and undefined-instruction traps with an acknowledge handshake. It also keeps a saturating stall counter.

---
 rtl/hazard_pkg.sv | 18 +
 rtl/hazard_compare.sv | 42 ++++
 rtl/hazard_controller.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard controller
//
// Purpose: FSM state encoding, trap cause codes and the register index type
// used by hazard_controller and hazard_compare.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    TRAP  = 2'b10
  } state_e;

  localparam logic [1:0] CAUSE_ALU = 2'b01;
  localparam logic [1:0] CAUSE_MEM = 2'b10;

  typedef logic [2:0] reg_idx_t;

endpackage

// File: rtl/hazard_compare.sv
// rtl/hazard_compare.sv - combinational load-use dependency detector
//
// Purpose: flags a hit when the load in EX writes a register that the ID
// bundle actually reads. r0 is an ordinary register here and is compared
// like any other index.
// Ports:
//   alu_rm_i, alu_rn_i, mem_rn_i, mem_rd_i  source indices of the ID bundle
//   use_alu_rm_i .. use_mem_rd_i            per-index "is read" flags
//   ex_mem_rd_i                             destination of the load in EX
//   ex_mem_read_i                           MEM slot in EX is a load
//   hit_o                                   load-use dependency present
module hazard_compare
  import hazard_pkg::*;
(
  input  reg_idx_t alu_rm_i,
  input  reg_idx_t alu_rn_i,
  input  reg_idx_t mem_rn_i,
  input  reg_idx_t mem_rd_i,
  input  logic     use_alu_rm_i,
  input  logic     use_alu_rn_i,
  input  logic     use_mem_rn_i,
  input  logic     use_mem_rd_i,
  input  reg_idx_t ex_mem_rd_i,
  input  logic     ex_mem_read_i,
  output logic     hit_o
);

  logic match_alu_rm;
  logic match_alu_rn;
  logic match_mem_rn;
  logic match_mem_rd;

  assign match_alu_rm = use_alu_rm_i && (alu_rm_i == ex_mem_rd_i);
  assign match_alu_rn = use_alu_rn_i && (alu_rn_i == ex_mem_rd_i);
  assign match_mem_rn = use_mem_rn_i && (mem_rn_i == ex_mem_rd_i);
  // mem_rd is a source only for stores, which is what use_mem_rd_i marks.
  assign match_mem_rd = use_mem_rd_i && (mem_rd_i == ex_mem_rd_i);

  assign hit_o = ex_mem_read_i &&
                 (match_alu_rm || match_alu_rn || match_mem_rn || match_mem_rd);

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - pipeline sequencing controller for the two-slot core
//
// Purpose: drives PC, IF/ID and ID/EX enables to handle load-use stalls,
// jump/branch squashes and undefined-instruction traps; keeps a saturating
// count of stall cycles.
// Ports:
//   clk, reset                    clock, asynchronous active-low reset
//   id_*                          ID bundle indices, use flags, jump, faults
//   ex_memRead, ex_mem_rd         load in EX and its destination
//   ex_branchTaken                branch in EX resolved taken
//   trap_ack                      trap acknowledge
//   pc_write, p1_*, p2_*          pipeline enables / flush / bubble (Mealy)
//   trap, trap_cause              registered trap status
//   stall_count                   saturating stall cycle counter
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned STALL_COUNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [2:0]               id_alu_rm,
  input  logic [2:0]               id_alu_rn,
  input  logic [2:0]               id_mem_rn,
  input  logic [2:0]               id_mem_rd,
  input  logic                     id_alu_useRm,
  input  logic                     id_alu_useRn,
  input  logic                     id_mem_useRn,
  input  logic                     id_mem_useRd,
  input  logic                     id_isJump,
  input  logic                     id_alu_undefinedInstruction,
  input  logic                     id_mem_undefinedInstruction,
  input  logic                     ex_memRead,
  input  logic [2:0]               ex_mem_rd,
  input  logic                     ex_branchTaken,
  input  logic                     trap_ack,
  output logic                     pc_write,
  output logic                     p1_pipeline_regWrite,
  output logic                     p1_flush,
  output logic                     p2_pipeline_regWrite,
  output logic                     p2_bubble,
  output logic                     trap,
  output logic [1:0]               trap_cause,
  output logic [STALL_COUNT_W-1:0] stall_count
);

  // First hit cycle is spent in RUN, so STALL covers the remaining cycles.
  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

  state_e                   state_q, state_d;
  logic [2:0]               cnt_q, cnt_d;
  logic                     trap_q, trap_d;
  logic [1:0]               cause_q, cause_d;
  logic [STALL_COUNT_W-1:0] stall_count_q, stall_count_d;

  logic cmp_hit;
  logic hit;
  logic fault;

  logic pc_write_c;
  logic p1_write_c;
  logic p1_flush_c;
  logic p2_write_c;
  logic p2_bubble_c;

  hazard_compare u_compare (
    .alu_rm_i      (id_alu_rm),
    .alu_rn_i      (id_alu_rn),
    .mem_rn_i      (id_mem_rn),
    .mem_rd_i      (id_mem_rd),
    .use_alu_rm_i  (id_alu_useRm),
    .use_alu_rn_i  (id_alu_useRn),
    .use_mem_rn_i  (id_mem_useRn),
    .use_mem_rd_i  (id_mem_useRd),
    .ex_mem_rd_i   (ex_mem_rd),
    .ex_mem_read_i (ex_memRead),
    .hit_o         (cmp_hit)
  );

  assign hit   = id_valid && cmp_hit;
  assign fault = id_valid && (id_alu_undefinedInstruction || id_mem_undefinedInstruction);

  always_comb begin
    pc_write_c  = 1'b1;
    p1_write_c  = 1'b1;
    p1_flush_c  = 1'b0;
    p2_write_c  = 1'b1;
    p2_bubble_c = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    trap_d      = trap_q;
    cause_d     = cause_q;

    case (state_q)
      RUN: begin
        if (ex_branchTaken) begin
          // Everything in ID is on the wrong path; squash it all.
          p1_flush_c  = 1'b1;
          p2_bubble_c = 1'b1;
        end else if (fault) begin
          pc_write_c  = 1'b0;
          p1_write_c  = 1'b0;
          p2_bubble_c = 1'b1;
          cause_d     = (id_alu_undefinedInstruction ? CAUSE_ALU : 2'b00) |
                        (id_mem_undefinedInstruction ? CAUSE_MEM : 2'b00);
          trap_d      = 1'b1;
          state_d     = TRAP;
        end else if (hit) begin
          pc_write_c  = 1'b0;
          p1_write_c  = 1'b0;
          p2_bubble_c = 1'b1;
          cnt_d       = STALL_RELOAD;
          if (STALL_RELOAD != 3'd0) begin
            state_d = STALL;
          end
        end else if (id_isJump) begin
          p1_flush_c = 1'b1;
        end
      end

      STALL: begin
        if (ex_branchTaken) begin
          p1_flush_c  = 1'b1;
          p2_bubble_c = 1'b1;
          cnt_d       = 3'd0;
          state_d     = RUN;
        end else begin
          pc_write_c  = 1'b0;
          p1_write_c  = 1'b0;
          p2_bubble_c = 1'b1;
          // <= 1 also recovers cleanly from a zero count.
          if (cnt_q <= 3'd1) begin
            cnt_d   = 3'd0;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end

      TRAP: begin
        pc_write_c = 1'b0;
        p1_write_c = 1'b0;
        p2_write_c = 1'b0;
        if (trap_ack) begin
          p1_flush_c  = 1'b1;
          p1_write_c  = 1'b1;
          p2_bubble_c = 1'b1;
          p2_write_c  = 1'b1;
          trap_d      = 1'b0;
          cause_d     = 2'b00;
          state_d     = RUN;
        end
      end

      default: begin
        state_d = RUN;
        cnt_d   = 3'd0;
        trap_d  = 1'b0;
        cause_d = 2'b00;
      end
    endcase
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_write_c && (state_q != TRAP) && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      cnt_q         <= 3'd0;
      trap_q        <= 1'b0;
      cause_q       <= 2'b00;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      trap_q        <= trap_d;
      cause_q       <= cause_d;
      stall_count_q <= stall_count_d;
    end
  end

  // While reset is held the pipeline is frozen and filled with NOPs.
  assign pc_write             = reset && pc_write_c;
  assign p1_pipeline_regWrite = reset && p1_write_c;
  assign p2_pipeline_regWrite = reset && p2_write_c;
  assign p1_flush             = !reset || p1_flush_c;
  assign p2_bubble            = !reset || p2_bubble_c;

  assign trap        = trap_q;
  assign trap_cause  = cause_q;
  assign stall_count = stall_count_q;

endmodule
